// File: rtl/encoder42_seq.sv
// Sequential 4-to-2 priority encoder with sticky pending requests.
//
// Request pulses on req[3:0] are captured into a sticky pending register.
// One 2-bit index per accepted transfer is offered on a valid/ready
// handshake, always choosing the highest pending index. Once an index is
// offered, it is held stable until it is accepted. A request that lands on
// a bit that is already pending is reported as an overrun and counted.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous flush of pending/offer state (counter kept)
//   req          request pulses, bit i registers event i
//   code         index of the offered event (3 = req[3])
//   valid        code is valid and offered
//   ready        consumer accepts code when valid & ready at a rising edge
//   pending      registered pending vector, including the offered bit
//   overrun      one-cycle pulse: a request hit an already-pending bit
//   overrun_cnt  saturating count of overrun pulses
module encoder42_seq #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [3:0]       req,
   output logic [1:0]       code,
   output logic             valid,
   input  logic             ready,
   output logic [3:0]       pending,
   output logic             overrun,
   output logic [CNT_W-1:0] overrun_cnt
);

   typedef enum logic [0:0] {StIdle, StOffer} state_e;

   state_e           state_q;
   logic [3:0]       pending_q;
   logic [1:0]       code_q;
   logic             valid_q;
   logic             overrun_q;
   logic [CNT_W-1:0] cnt_q;

   logic       accept;
   logic [3:0] ack_mask;
   logic [3:0] pend_next;
   logic       ovr_hit;
   logic [1:0] prio_next;
   logic       cnt_full;

   always_comb begin
      accept    = valid_q & ready;
      ack_mask  = accept ? (4'b0001 << code_q) : 4'b0000;
      // A request on the bit being acknowledged re-arms it; not an overrun.
      pend_next = (pending_q & ~ack_mask) | req;
      ovr_hit   = |(req & pending_q & ~ack_mask);
      cnt_full  = (cnt_q == {CNT_W{1'b1}});
   end

   // Highest set bit of pend_next.
   always_comb begin
      prio_next = 2'd0;
      if (pend_next[3]) begin
         prio_next = 2'd3;
      end else if (pend_next[2]) begin
         prio_next = 2'd2;
      end else if (pend_next[1]) begin
         prio_next = 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pending_q <= 4'b0000;
         code_q    <= 2'd0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         cnt_q     <= '0;
      end else if (clear) begin
         // Flush wins over same-cycle requests and accepts; counter is kept.
         state_q   <= StIdle;
         pending_q <= 4'b0000;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         pending_q <= pend_next;
         overrun_q <= ovr_hit;
         if (ovr_hit && !cnt_full) begin
            cnt_q <= cnt_q + 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (pend_next != 4'b0000) begin
                  code_q  <= prio_next;
                  valid_q <= 1'b1;
                  state_q <= StOffer;
               end
            end
            StOffer: begin
               // Offer is frozen until accepted, even if higher priority arrives.
               if (accept) begin
                  if (pend_next != 4'b0000) begin
                     code_q <= prio_next;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign code        = code_q;
   assign valid       = valid_q;
   assign pending     = pending_q;
   assign overrun     = overrun_q;
   assign overrun_cnt = cnt_q;

endmodule

// File: tb/tb_encoder42_seq.sv
// Self-checking bench for encoder42_seq: table-driven per-cycle vectors with
// a scoreboard queue, plus hand-written async-reset and saturation sequences.
module tb_encoder42_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic [3:0] req;
   logic       ready;
   logic [1:0] code;
   logic       valid;
   logic [3:0] pending;
   logic       overrun;
   logic [7:0] overrun_cnt;

   // Second instance with a narrow counter for the saturation check.
   logic       clear2;
   logic [3:0] req2;
   logic       ready2;
   logic [1:0] code2;
   logic       valid2;
   logic [3:0] pending2;
   logic       overrun2;
   logic [1:0] overrun_cnt2;

   always #5 clk = ~clk;

   encoder42_seq #(.CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .req         (req),
      .code        (code),
      .valid       (valid),
      .ready       (ready),
      .pending     (pending),
      .overrun     (overrun),
      .overrun_cnt (overrun_cnt)
   );

   encoder42_seq #(.CNT_W(2)) dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear2),
      .req         (req2),
      .code        (code2),
      .valid       (valid2),
      .ready       (ready2),
      .pending     (pending2),
      .overrun     (overrun2),
      .overrun_cnt (overrun_cnt2)
   );

   // Inputs for one cycle and the outputs expected just after that edge.
   // cc=1 means code is checked even when valid is 0.
   typedef struct {
      logic [3:0] req;
      logic       ready;
      logic       clear;
      logic       ev;
      logic       cc;
      logic [1:0] ec;
      logic [3:0] ep;
      logic       eo;
      logic [7:0] en;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic cl,
                               input logic ev, input logic cc, input logic [1:0] ec,
                               input logic [3:0] ep, input logic eo, input logic [7:0] en);
      vec_t v;
      v.req = r; v.ready = rd; v.clear = cl;
      v.ev = ev; v.cc = cc; v.ec = ec; v.ep = ep; v.eo = eo; v.en = en;
      return v;
   endfunction

   task automatic check(input string name, input vec_t e);
      logic ok;
      n_checks++;
      ok = (valid === e.ev) && (pending === e.ep) && (overrun === e.eo) &&
           (overrun_cnt === e.en) && (!(e.ev || e.cc) || (code === e.ec));
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got valid=%0b code=%0d pending=%b overrun=%0b cnt=%0d, want valid=%0b code=%0d pending=%b overrun=%0b cnt=%0d",
                  name, valid, code, pending, overrun, overrun_cnt,
                  e.ev, e.ec, e.ep, e.eo, e.en);
      end
   endtask

   // Drive one vector, queue its expectation, compare after the edge.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      req   = v.req;
      ready = v.ready;
      clear = v.clear;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d", idx), e);
   endtask

   initial begin
      vec_t z;
      logic [1:0] sat_exp[6];
      rst_n = 1'b0; clear = 1'b0; req = 4'b0; ready = 1'b0;
      clear2 = 1'b0; req2 = 4'b0; ready2 = 1'b0;
      z = mk(4'b0, 0, 0, 0, 1, 2'd0, 4'b0000, 0, 8'd0);

      // Idle after reset
      for (int i = 0; i < 5; i++) tbl.push_back(z);
      // Single event
      tbl.push_back(mk(4'b0100, 1, 0, 1, 1, 2'd2, 4'b0100, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd0));
      // Priority and hold: higher request does not disturb the offer
      tbl.push_back(mk(4'b0011, 0, 0, 1, 1, 2'd1, 4'b0011, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 1, 2'd1, 4'b0011, 0, 8'd0));
      tbl.push_back(mk(4'b1000, 0, 0, 1, 1, 2'd1, 4'b1011, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 1, 2'd1, 4'b1011, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 1, 1, 2'd3, 4'b1001, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 1, 1, 2'd0, 4'b0001, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd0));
      // Back-to-back drain, no bubble, no overrun
      tbl.push_back(mk(4'b1111, 1, 0, 1, 1, 2'd3, 4'b1111, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 1, 1, 2'd2, 4'b0111, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 1, 1, 2'd1, 4'b0011, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 1, 1, 2'd0, 4'b0001, 0, 8'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd0));
      // Overrun on held request; re-arm during accept is not an overrun
      tbl.push_back(mk(4'b0001, 0, 0, 1, 1, 2'd0, 4'b0001, 0, 8'd0));
      tbl.push_back(mk(4'b0001, 0, 0, 1, 1, 2'd0, 4'b0001, 1, 8'd1));
      tbl.push_back(mk(4'b0001, 0, 0, 1, 1, 2'd0, 4'b0001, 1, 8'd2));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 1, 2'd0, 4'b0001, 0, 8'd2));
      tbl.push_back(mk(4'b0001, 1, 0, 1, 1, 2'd0, 4'b0001, 0, 8'd2));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd2));
      // Multi-bit collision counts once
      tbl.push_back(mk(4'b0011, 0, 0, 1, 1, 2'd1, 4'b0011, 0, 8'd2));
      tbl.push_back(mk(4'b0011, 0, 0, 1, 1, 2'd1, 4'b0011, 1, 8'd3));
      tbl.push_back(mk(4'b0000, 1, 0, 1, 1, 2'd0, 4'b0001, 0, 8'd3));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd3));
      // Clear beats same-cycle req and accept; counter preserved
      tbl.push_back(mk(4'b0110, 0, 0, 1, 1, 2'd2, 4'b0110, 0, 8'd3));
      tbl.push_back(mk(4'b1000, 1, 1, 0, 0, 2'd0, 4'b0000, 0, 8'd3));
      tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd3));
      // Clear also suppresses an overrun collision
      tbl.push_back(mk(4'b0010, 0, 0, 1, 1, 2'd1, 4'b0010, 0, 8'd3));
      tbl.push_back(mk(4'b0010, 0, 1, 0, 0, 2'd0, 4'b0000, 0, 8'd3));
      tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd3));

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      #1;
      check("reset", z);
      rst_n = 1'b1;

      foreach (tbl[i]) apply(tbl[i], i);

      // Async reset mid-offer: outputs drop before any clock edge
      apply(mk(4'b0100, 0, 0, 1, 1, 2'd2, 4'b0100, 0, 8'd3), 900);
      req = 4'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", z);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Narrow counter saturates at 3 after 5 overruns
      sat_exp[0] = 2'd0; sat_exp[1] = 2'd1; sat_exp[2] = 2'd2;
      sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;
      for (int i = 0; i < 6; i++) begin
         req2 = 4'b0001;
         @(posedge clk);
         #1;
         n_checks++;
         if (overrun_cnt2 !== sat_exp[i] || overrun2 !== (i > 0) ||
             valid2 !== 1'b1 || pending2 !== 4'b0001 || code2 !== 2'd0) begin
            n_fail++;
            $display("FAIL sat%0d: got cnt=%0d overrun=%0b valid=%0b pending=%b code=%0d, want cnt=%0d overrun=%0b valid=1 pending=0001 code=0",
                     i, overrun_cnt2, overrun2, valid2, pending2, code2, sat_exp[i], (i > 0));
         end
      end
      req2 = 4'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
